// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers: ID/EX payload layout,
// control-bundle bit positions and the NOP control encoding.
package pipe_pkg;

    localparam int unsigned IDEX_DATA_W = 106;
    localparam int unsigned CTRL_W_DEF  = 16;
    localparam int unsigned CNT_W_DEF   = 16;

    // ID/EX payload packing, LSB first: rt, rs, data2, data1, pc
    localparam int unsigned RT_LSB    = 0;
    localparam int unsigned RS_LSB    = 5;
    localparam int unsigned DATA2_LSB = 10;
    localparam int unsigned DATA1_LSB = 42;
    localparam int unsigned PC_LSB    = 74;

    // Control bundle bit indices
    localparam int unsigned REGDST    = 0;
    localparam int unsigned ALUSRC    = 1;
    localparam int unsigned REGWRITE  = 2;
    localparam int unsigned MEMTOREG  = 3;
    localparam int unsigned MEMWRITE  = 4;
    localparam int unsigned MEMREAD   = 5;
    localparam int unsigned EXTOP     = 6;
    localparam int unsigned ALUOP_LSB = 7;
    localparam int unsigned ALUOP_MSB = 8;

    // An all-zero control bundle is a NOP: no register or memory write.
    localparam int unsigned CTRL_NOP = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } idex_payload_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    function automatic logic [IDEX_DATA_W-1:0] pack_idex(input idex_payload_t p);
        logic [IDEX_DATA_W-1:0] v;
        v = '0;
        v[PC_LSB    +: 32] = p.pc;
        v[DATA1_LSB +: 32] = p.data1;
        v[DATA2_LSB +: 32] = p.data2;
        v[RS_LSB    +: 5]  = p.rs;
        v[RT_LSB    +: 5]  = p.rt;
        return v;
    endfunction

    function automatic idex_payload_t unpack_idex(input logic [IDEX_DATA_W-1:0] v);
        idex_payload_t p;
        p.pc    = v[PC_LSB    +: 32];
        p.data1 = v[DATA1_LSB +: 32];
        p.data2 = v[DATA2_LSB +: 32];
        p.rs    = v[RS_LSB    +: 5];
        p.rt    = v[RT_LSB    +: 5];
        return p;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream bundle of a pipeline register; master is the stage
// feeding it plus the hazard unit, slave is the register itself.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = IDEX_DATA_W,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              stall_i;
    logic              flush_i;
    logic              cnt_clr_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output valid_i, data_i, ctrl_i, stall_i, flush_i, cnt_clr_i,
        input  valid_o, data_o, ctrl_o, stall_cnt_o
    );

    modport slave (
        input  valid_i, data_i, ctrl_i, stall_i, flush_i, cnt_clr_i,
        output valid_o, data_o, ctrl_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_slice.sv
// One register slice: valid/ctrl/data with flush > stall > advance priority.
// Invalid slices always carry the NOP control bundle.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = IDEX_DATA_W,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);
    localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            // Data is left alone on a squash; only the slot is killed.
            valid_d = 1'b0;
            ctrl_d  = NOP;
        end else if (!stall_i) begin
            valid_d = valid_i;
            ctrl_d  = valid_i ? ctrl_i : NOP;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= NOP;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH chained slices sharing
// stall/flush, plus a saturating count of stalled cycles.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = IDEX_DATA_W,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    pipe_stage_reg_if.slave bus
);
    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    // Index 0 is the upstream input; index DEPTH is the last slice.
    logic              valid_w [DEPTH+1];
    logic [CTRL_W-1:0] ctrl_w  [DEPTH+1];
    logic [DATA_W-1:0] data_w  [DEPTH+1];

    assign valid_w[0] = bus.valid_i;
    assign ctrl_w[0]  = bus.ctrl_i;
    assign data_w[0]  = bus.data_i;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slice
            pipe_slice #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_slice (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .stall_i (bus.stall_i),
                .flush_i (bus.flush_i),
                .valid_i (valid_w[gi]),
                .ctrl_i  (ctrl_w[gi]),
                .data_i  (data_w[gi]),
                .valid_o (valid_w[gi+1]),
                .ctrl_o  (ctrl_w[gi+1]),
                .data_o  (data_w[gi+1])
            );
        end
    endgenerate

    assign bus.valid_o = valid_w[DEPTH];
    assign bus.ctrl_o  = ctrl_w[DEPTH];
    assign bus.data_o  = data_w[DEPTH];

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr_i) begin
            cnt_d = '0;
        end else if (bus.stall_i && !bus.flush_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a DEPTH=2 instance for latency/reset and a DEPTH=1,
// CNT_W=4 instance for stall, flush, bubble and counter saturation.
module tb_pipe_stage_reg;
    localparam int DW = 106;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) a_if ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4))  b_if ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2), .CNT_W(16)) u_a (
        .clk_i (clk), .rst_n_i (rst_n), .bus (a_if)
    );
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1), .CNT_W(4)) u_b (
        .clk_i (clk), .rst_n_i (rst_n), .bus (b_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_if.valid_i = 0; a_if.data_i = '0; a_if.ctrl_i = '0;
        a_if.stall_i = 0; a_if.flush_i = 0; a_if.cnt_clr_i = 0;
        b_if.valid_i = 0; b_if.data_i = '0; b_if.ctrl_i = '0;
        b_if.stall_i = 0; b_if.flush_i = 0; b_if.cnt_clr_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #3;
        total_cnt++; if (a_if.valid_o !== 1'b0) $display("FAIL reset_a_valid: got %0h want 0", a_if.valid_o); else pass_cnt++;
        total_cnt++; if (a_if.ctrl_o !== 16'h0) $display("FAIL reset_a_ctrl: got %0h want 0", a_if.ctrl_o); else pass_cnt++;
        total_cnt++; if (a_if.data_o !== '0) $display("FAIL reset_a_data: got %0h want 0", a_if.data_o); else pass_cnt++;
        total_cnt++; if (a_if.stall_cnt_o !== 16'h0) $display("FAIL reset_a_cnt: got %0h want 0", a_if.stall_cnt_o); else pass_cnt++;
        total_cnt++; if (b_if.valid_o !== 1'b0) $display("FAIL reset_b_valid: got %0h want 0", b_if.valid_o); else pass_cnt++;
        total_cnt++; if (b_if.stall_cnt_o !== 4'h0) $display("FAIL reset_b_cnt: got %0h want 0", b_if.stall_cnt_o); else pass_cnt++;
        #9;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pass_through();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                a_if.valid_i = 1; a_if.data_i = DW'(32'hA + i); a_if.ctrl_i = 16'h00FF;
            end else begin
                a_if.valid_i = 0; a_if.data_i = '0; a_if.ctrl_i = 16'h00FF;
            end
            tick();
            if (i >= 1 && i <= 4) begin
                exp_d = DW'(32'hA + i - 1);
                total_cnt++; if (a_if.data_o !== exp_d) $display("FAIL pass_data[%0d]: got %0h want %0h", i, a_if.data_o, exp_d); else pass_cnt++;
                total_cnt++; if (a_if.ctrl_o !== 16'h00FF) $display("FAIL pass_ctrl[%0d]: got %0h want ff", i, a_if.ctrl_o); else pass_cnt++;
                total_cnt++; if (a_if.valid_o !== 1'b1) $display("FAIL pass_valid[%0d]: got %0h want 1", i, a_if.valid_o); else pass_cnt++;
            end else begin
                total_cnt++; if (a_if.valid_o !== 1'b0) $display("FAIL pass_edge_valid[%0d]: got %0h want 0", i, a_if.valid_o); else pass_cnt++;
                total_cnt++; if (a_if.ctrl_o !== 16'h0) $display("FAIL pass_edge_ctrl[%0d]: got %0h want 0", i, a_if.ctrl_o); else pass_cnt++;
            end
            $display("pass-through cycle %0d: valid_o=%0b data_o=%0h ctrl_o=%0h", i, a_if.valid_o, a_if.data_o, a_if.ctrl_o);
        end
        a_if.ctrl_i = '0;
    endtask

    task automatic test_stall();
        b_if.valid_i = 1; b_if.data_i = DW'(5); b_if.ctrl_i = 16'h0011;
        tick();
        total_cnt++; if (b_if.data_o !== DW'(5)) $display("FAIL stall_load: got %0h want 5", b_if.data_o); else pass_cnt++;
        b_if.data_i = DW'(6); b_if.stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (b_if.data_o !== DW'(5)) $display("FAIL stall_hold[%0d]: got %0h want 5", i, b_if.data_o); else pass_cnt++;
            $display("stall cycle %0d: data_o=%0h cnt=%0d", i, b_if.data_o, b_if.stall_cnt_o);
        end
        total_cnt++; if (b_if.stall_cnt_o !== 4'd3) $display("FAIL stall_cnt: got %0d want 3", b_if.stall_cnt_o); else pass_cnt++;
        b_if.stall_i = 0;
        tick();
        total_cnt++; if (b_if.data_o !== DW'(6)) $display("FAIL stall_release: got %0h want 6", b_if.data_o); else pass_cnt++;
        total_cnt++; if (b_if.stall_cnt_o !== 4'd3) $display("FAIL stall_cnt_after: got %0d want 3", b_if.stall_cnt_o); else pass_cnt++;
    endtask

    task automatic test_flush_vs_stall();
        b_if.stall_i = 1; b_if.flush_i = 1;
        b_if.valid_i = 1; b_if.data_i = DW'(7); b_if.ctrl_i = 16'hFFFF;
        tick();
        $display("flush+stall: valid_o=%0b ctrl_o=%0h data_o=%0h cnt=%0d", b_if.valid_o, b_if.ctrl_o, b_if.data_o, b_if.stall_cnt_o);
        total_cnt++; if (b_if.valid_o !== 1'b0) $display("FAIL flush_valid: got %0h want 0", b_if.valid_o); else pass_cnt++;
        total_cnt++; if (b_if.ctrl_o !== 16'h0) $display("FAIL flush_ctrl: got %0h want 0", b_if.ctrl_o); else pass_cnt++;
        total_cnt++; if (b_if.data_o !== DW'(6)) $display("FAIL flush_data_hold: got %0h want 6", b_if.data_o); else pass_cnt++;
        total_cnt++; if (b_if.stall_cnt_o !== 4'd3) $display("FAIL flush_cnt: got %0d want 3", b_if.stall_cnt_o); else pass_cnt++;
        b_if.stall_i = 0; b_if.flush_i = 0;
        tick();
        total_cnt++; if (b_if.valid_o !== 1'b1) $display("FAIL flush_next_valid: got %0h want 1", b_if.valid_o); else pass_cnt++;
        total_cnt++; if (b_if.ctrl_o !== 16'hFFFF) $display("FAIL flush_next_ctrl: got %0h want ffff", b_if.ctrl_o); else pass_cnt++;
        total_cnt++; if (b_if.data_o !== DW'(7)) $display("FAIL flush_next_data: got %0h want 7", b_if.data_o); else pass_cnt++;
    endtask

    task automatic test_bubble();
        b_if.valid_i = 0; b_if.ctrl_i = 16'h0004; b_if.data_i = DW'(32'h123);
        tick();
        $display("bubble: valid_o=%0b ctrl_o=%0h data_o=%0h", b_if.valid_o, b_if.ctrl_o, b_if.data_o);
        total_cnt++; if (b_if.ctrl_o !== 16'h0) $display("FAIL bubble_ctrl: got %0h want 0", b_if.ctrl_o); else pass_cnt++;
        total_cnt++; if (b_if.valid_o !== 1'b0) $display("FAIL bubble_valid: got %0h want 0", b_if.valid_o); else pass_cnt++;
        total_cnt++; if (b_if.data_o !== DW'(32'h123)) $display("FAIL bubble_data: got %0h want 123", b_if.data_o); else pass_cnt++;
        b_if.ctrl_i = '0;
    endtask

    task automatic test_counter();
        b_if.cnt_clr_i = 1;
        tick();
        b_if.cnt_clr_i = 0;
        total_cnt++; if (b_if.stall_cnt_o !== 4'd0) $display("FAIL cnt_clear: got %0d want 0", b_if.stall_cnt_o); else pass_cnt++;
        b_if.stall_i = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) begin
                total_cnt++; if (b_if.stall_cnt_o !== 4'd15) $display("FAIL cnt_reach_max: got %0d want 15", b_if.stall_cnt_o); else pass_cnt++;
            end
        end
        $display("counter after 20 stalls: %0d", b_if.stall_cnt_o);
        total_cnt++; if (b_if.stall_cnt_o !== 4'd15) $display("FAIL cnt_saturate: got %0d want 15", b_if.stall_cnt_o); else pass_cnt++;
        b_if.cnt_clr_i = 1;
        tick();
        b_if.cnt_clr_i = 0; b_if.stall_i = 0;
        total_cnt++; if (b_if.stall_cnt_o !== 4'd0) $display("FAIL cnt_clr_beats_stall: got %0d want 0", b_if.stall_cnt_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        a_if.valid_i = 1; a_if.data_i = DW'(32'h11); a_if.ctrl_i = 16'h00FF;
        tick();
        a_if.data_i = DW'(32'h22);
        tick();
        total_cnt++; if (a_if.data_o !== DW'(32'h11)) $display("FAIL rstmid_pre_data: got %0h want 11", a_if.data_o); else pass_cnt++;
        a_if.stall_i = 1;
        tick();
        total_cnt++; if (a_if.stall_cnt_o !== 16'd1) $display("FAIL rstmid_pre_cnt: got %0d want 1", a_if.stall_cnt_o); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid reset: valid_o=%0b ctrl_o=%0h data_o=%0h cnt=%0d", a_if.valid_o, a_if.ctrl_o, a_if.data_o, a_if.stall_cnt_o);
        total_cnt++; if (a_if.valid_o !== 1'b0) $display("FAIL rstmid_valid: got %0h want 0", a_if.valid_o); else pass_cnt++;
        total_cnt++; if (a_if.ctrl_o !== 16'h0) $display("FAIL rstmid_ctrl: got %0h want 0", a_if.ctrl_o); else pass_cnt++;
        total_cnt++; if (a_if.data_o !== '0) $display("FAIL rstmid_data: got %0h want 0", a_if.data_o); else pass_cnt++;
        total_cnt++; if (a_if.stall_cnt_o !== 16'd0) $display("FAIL rstmid_cnt: got %0d want 0", a_if.stall_cnt_o); else pass_cnt++;
        idle_inputs();
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall();
        test_flush_vs_stall();
        test_bubble();
        test_counter();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
